apb_arbiter_master: RTL
=======================

APB_ARBITER_MASTER -- requirements
Module: apb_arbiter_master

Interface
Parameters:
REQ-001 SHALL have parameter ADDR_W, default 32, APB/requester address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB/requester data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles with PREADY low before forced termination (legal range 1..255).
Ports:
REQ-004 SHALL have PCLK  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have PRESET  input  1  reset, synchronous, active-high.
REQ-006 SHALL have req_valid  input  2  per-requester command valid.
REQ-007 SHALL have req_write  input  2  per-requester direction: 1 write, 0 read.
REQ-008 SHALL have req_addr  input  2*ADDR_W  per-requester address; requester i at bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have req_wdata  input  2*DATA_W  per-requester write data, packed as req_addr.
REQ-010 SHALL have req_ready  output  2  one-hot command accept pulse.
REQ-011 SHALL have rsp_valid  output  2  one-hot response pulse, one cycle.
REQ-012 SHALL have rsp_rdata  output  DATA_W  read data of the completed transfer.
REQ-013 SHALL have rsp_err  output  1  error flag of the completed transfer.
REQ-014 SHALL have busy  output  1  high in SETUP and ACCESS.
REQ-015 SHALL have PSEL, PENABLE, PWRITE  output  1 each  APB master controls.
REQ-016 SHALL have PADDR  output  ADDR_W and PWDATA  output  DATA_W  APB master address/data.
REQ-017 SHALL have PRDATA  input  DATA_W, PREADY  input  1, PSLVERR  input  1  APB completer returns.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-019 IDLE: if any req_valid, SHALL select requester g by round-robin, assert req_ready[g] combinationally in that cycle, latch req_write/addr/wdata of g, go SETUP; otherwise stay IDLE.
REQ-020 Arbitration: SHALL keep a 1-bit priority pointer; both valid -> grant pointer; one valid -> grant it; after any grant, pointer SHALL point to the non-granted requester.
REQ-021 SETUP: SHALL drive PSEL=1, PENABLE=0, latched PADDR/PWRITE/PWDATA; unconditionally go ACCESS next cycle.
REQ-022 ACCESS: SHALL drive PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA SHALL remain unchanged from SETUP.
REQ-023 ACCESS with PREADY=1: SHALL go IDLE; next cycle rsp_valid[g]=1, rsp_err=PSLVERR, rsp_rdata=PRDATA for reads and 0 for writes, both sampled on the completing edge.
REQ-024 ACCESS with PREADY=0: SHALL increment a wait counter (cleared on entry to SETUP); when counter reaches TIMEOUT with PREADY still 0, SHALL go IDLE and issue rsp_valid[g] with rsp_err=1, rsp_rdata=0.
REQ-025 PREADY=1 on the same cycle the counter hits TIMEOUT SHALL complete normally (PREADY wins).
REQ-026 Latency: accept cycle -> SETUP -> ACCESS -> rsp_valid; with zero wait states rsp_valid SHALL assert 3 cycles after the req_ready cycle.
REQ-027 A new command SHALL be acceptable in the same IDLE cycle that rsp_valid is high for the previous one.
REQ-028 PSEL, PENABLE, busy, rsp_valid, rsp_rdata, rsp_err, PADDR, PWRITE, PWDATA SHALL be driven from registers.
REQ-029 In IDLE, PSEL=PENABLE=0; PADDR/PWDATA/PWRITE SHALL hold their last values.
REQ-030 rsp_rdata/rsp_err SHALL hold their last values when rsp_valid=0.
REQ-031 req_valid deassertion by a requester outside its accept cycle SHALL have no effect; no command is dropped once req_ready pulses.

Reset
REQ-032 While PRESET=1 at a rising edge: state IDLE, pointer=0, wait counter=0, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=0.
REQ-033 Reset asserted mid-transfer SHALL abort it with no rsp_valid issued; PSEL drops on the reset edge.

Verification
REQ-034 Single write, req 0, addr 0x0, data 0xDEADBEEF, PREADY=1 -> req_ready=01, SETUP then ACCESS with PADDR=0x0, PWDATA=0xDEADBEEF, PWRITE=1; rsp_valid=01, rsp_err=0, rsp_rdata=0 three cycles after accept.
REQ-035 Read from req 1, completer returns PRDATA=0x12345678 after 2 wait states -> ACCESS lasts 3 cycles; rsp_valid=10, rsp_rdata=0x12345678.
REQ-036 Both requesters valid continuously after reset -> grants alternate 0,1,0,1; each rsp_valid matches the granted requester.
REQ-037 PREADY held 0, TIMEOUT=16 -> after 16 ACCESS wait cycles FSM returns IDLE; rsp_err=1, rsp_rdata=0; PSLVERR=1 with PREADY=1 -> rsp_err=1.
REQ-038 PRESET pulsed during ACCESS -> next edge PSEL=PENABLE=0, busy=0, no rsp_valid; pointer=0, requester 0 wins next simultaneous request.

Source files
------------

// File: rtl/apb_arbiter_master.sv
// ----------------------------------------------------------------------------
// apb_arbiter_master
//
// Two-requester round-robin arbiter that turns a winning command into one
// APB transfer (IDLE -> SETUP -> ACCESS) and returns a one-cycle response
// pulse to the winning requester. An ACCESS phase that sees PREADY low for
// TIMEOUT consecutive cycles is forcibly ended with an error response.
//
// Ports
//   PCLK, PRESET          clock, synchronous active-high reset
//   req_valid/req_write   per-requester command valid / direction (1 = write)
//   req_addr/req_wdata    per-requester address / write data, requester i in
//                         slice [i*W +: W]
//   req_ready             one-hot accept pulse (combinational, IDLE only)
//   rsp_valid             one-hot one-cycle response pulse
//   rsp_rdata/rsp_err     response data / error, held between responses
//   busy                  high while in SETUP or ACCESS
//   PSEL..PWDATA          APB master outputs, all registered
//   PRDATA/PREADY/PSLVERR APB completer returns
// ----------------------------------------------------------------------------
module apb_arbiter_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_W-1:0]     PADDR,
    output logic [DATA_W-1:0]     PWDATA,
    input  logic [DATA_W-1:0]     PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Wait-counter value seen on the last permitted PREADY-low ACCESS cycle.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                gnt_q, gnt_d;
    logic [7:0]          wait_cnt_q, wait_cnt_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                busy_q, busy_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic                gnt_s;
    logic                accept_s;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Round-robin pick: pointer breaks ties, a lone requester always wins.
    always_comb begin
        gnt_s = 1'b0;
        if (req_valid == 2'b11) begin
            gnt_s = ptr_q;
        end else if (req_valid[1]) begin
            gnt_s = 1'b1;
        end else begin
            gnt_s = 1'b0;
        end
    end

    // A command is taken only in IDLE; reset suppresses the accept pulse.
    assign accept_s  = (state_q == ST_IDLE) && (|req_valid) && !PRESET;
    assign req_ready = accept_s ? onehot2(gnt_s) : 2'b00;

    // Next-state and next-output computation for the transfer FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        wait_cnt_d  = wait_cnt_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        busy_d      = 1'b0;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d    = ST_SETUP;
                    gnt_d      = gnt_s;
                    ptr_d      = ~gnt_s;
                    wait_cnt_d = 8'd0;
                    pwrite_d   = gnt_s ? req_write[1] : req_write[0];
                    paddr_d    = gnt_s ? req_addr[2*ADDR_W-1:ADDR_W]
                                       : req_addr[ADDR_W-1:0];
                    pwdata_d   = gnt_s ? req_wdata[2*DATA_W-1:DATA_W]
                                       : req_wdata[DATA_W-1:0];
                    psel_d     = 1'b1;
                    busy_d     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
                busy_d    = 1'b1;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    // Completion takes priority over a coincident timeout.
                    state_d     = ST_IDLE;
                    rsp_valid_d = onehot2(gnt_q);
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = pwrite_q ? {DATA_W{1'b0}} : PRDATA;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = onehot2(gnt_q);
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = {DATA_W{1'b0}};
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    psel_d     = 1'b1;
                    penable_d  = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            gnt_q       <= 1'b0;
            wait_cnt_q  <= 8'd0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= {ADDR_W{1'b0}};
            pwdata_q    <= {DATA_W{1'b0}};
            busy_q      <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= {DATA_W{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            wait_cnt_q  <= wait_cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
